controle_jogo: RTL and testbench

CONTROLE_JOGO -- requirements
Module: controle_jogo

---
 rtl/controle_jogo_pkg.sv | 17 +
 rtl/controle_jogo_detector_borda.sv | 19 +
 rtl/controle_jogo.sv | 125 ++++++++++++
 tb/tb_controle_jogo.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/controle_jogo_pkg.sv
// Shared game-control types and sizing: FSM state encoding, default attempt count,
// width of the remaining-attempts counter.
package controle_jogo_pkg;

  localparam int MAX_TENT_PADRAO = 5;
  localparam int LARG_REST       = 3;

  typedef enum logic [2:0] {
    OCIOSO,
    ESPERA,
    CAPTURA,
    AVALIA,
    VITORIA,
    DERROTA
  } estado_t;

endpackage

// File: rtl/controle_jogo_detector_borda.sv
// Rising-edge detector for an already-synchronised button level; zero latency,
// edge = level high now and low on the previous clock (history cleared by reset).
module detector_borda (
  input  logic clk,
  input  logic rst_n,
  input  logic i_nivel,
  output logic o_borda
);

  logic r_anterior;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_anterior <= 1'b0;
    else        r_anterior <= i_nivel;
  end

  assign o_borda = i_nivel & ~r_anterior;

endmodule

// File: rtl/controle_jogo.sv
// Guessing-game round controller: confirma edge -> captura next cycle, verdict two cycles later;
// no backpressure, inputs are levels. Score counter built only with PONTUACAO_EN defined.
module controle_jogo
  import controle_jogo_pkg::*;
#(
  parameter int MAX_TENT = MAX_TENT_PADRAO,
  parameter int LARG_PTS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 confirma,
  input  logic                 novo_jogo,
  input  logic                 igual,
  input  logic                 ate3,
  input  logic                 errada,
  output logic                 captura,
  output logic [LARG_REST-1:0] restantes,
  output logic                 quente,
  output logic                 venceu,
  output logic                 perdeu,
  output logic [LARG_PTS-1:0]  pontos
);

  estado_t              r_estado;
  estado_t              w_prox;
  logic                 w_borda_conf;
  logic                 w_borda_novo;
  logic                 w_carrega;
  logic                 w_avaliar;
  logic                 w_unico;
  logic                 w_acerto;
  logic                 w_so_ate3;
  logic [LARG_REST-1:0] w_rest_dec;
  logic [LARG_REST-1:0] r_restantes;
  logic                 r_quente;
  logic                 r_venceu;
  logic                 r_perdeu;

  detector_borda u_borda_conf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_nivel (confirma),
    .o_borda (w_borda_conf)
  );

  detector_borda u_borda_novo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_nivel (novo_jogo),
    .o_borda (w_borda_novo)
  );

  // Exactly one verdict flag is trusted; zero or several collapse to "wrong".
  assign w_unico    = (igual ^ ate3 ^ errada) & ~(igual & ate3 & errada);
  assign w_acerto   = w_unico & igual;
  assign w_so_ate3  = w_unico & ate3;
  assign w_rest_dec = r_restantes - LARG_REST'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_estado <= OCIOSO;
    else        r_estado <= w_prox;
  end

  always_comb begin
    w_prox    = r_estado;
    w_carrega = 1'b0;
    w_avaliar = 1'b0;
    if (w_borda_novo) begin
      w_prox    = ESPERA;
      w_carrega = 1'b1;
    end else begin
      case (r_estado)
        ESPERA:  if (w_borda_conf) w_prox = CAPTURA;
        CAPTURA: w_prox = AVALIA;
        AVALIA: begin
          w_avaliar = 1'b1;
          if (w_acerto)                 w_prox = VITORIA;
          else if (w_rest_dec == '0)    w_prox = DERROTA;
          else                          w_prox = ESPERA;
        end
        default: w_prox = r_estado;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_restantes <= '0;
      r_quente    <= 1'b0;
      r_venceu    <= 1'b0;
      r_perdeu    <= 1'b0;
    end else if (w_carrega) begin
      r_restantes <= LARG_REST'(MAX_TENT);
      r_quente    <= 1'b0;
      r_venceu    <= 1'b0;
      r_perdeu    <= 1'b0;
    end else if (w_avaliar) begin
      r_restantes <= w_rest_dec;
      r_quente    <= w_so_ate3;
      r_venceu    <= w_acerto;
      r_perdeu    <= ~w_acerto & (w_rest_dec == '0);
    end
  end

`ifdef PONTUACAO_EN
  logic [LARG_PTS-1:0] r_pontos;

  // Saturating win counter, untouched by new rounds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         r_pontos <= '0;
    else if (w_avaliar && w_acerto && (r_pontos != '1)) r_pontos <= r_pontos + LARG_PTS'(1);
  end

  assign pontos = r_pontos;
`else
  assign pontos = '0;
`endif

  assign captura   = (r_estado == CAPTURA);
  assign restantes = r_restantes;
  assign quente    = r_quente;
  assign venceu    = r_venceu;
  assign perdeu    = r_perdeu;

endmodule

// File: tb/tb_controle_jogo.sv
// Bench for controle_jogo: directed vector table, hand-written corner sequences,
// then random stimulus against a round-level game model.
module tb_controle_jogo;

  localparam int MAX_TENT = 5;
  localparam int LARG_PTS = 4;
  localparam int PTS_MAX  = (1 << LARG_PTS) - 1;
`ifdef PONTUACAO_EN
  localparam int PONT_EN = 1;
`else
  localparam int PONT_EN = 0;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic                confirma, novo_jogo, igual, ate3, errada;
  logic                captura, quente, venceu, perdeu;
  logic [2:0]          restantes;
  logic [LARG_PTS-1:0] pontos;

  int n_aval   = 0;
  int n_falhas = 0;

  controle_jogo #(.MAX_TENT(MAX_TENT), .LARG_PTS(LARG_PTS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .confirma  (confirma),
    .novo_jogo (novo_jogo),
    .igual     (igual),
    .ate3      (ate3),
    .errada    (errada),
    .captura   (captura),
    .restantes (restantes),
    .quente    (quente),
    .venceu    (venceu),
    .perdeu    (perdeu),
    .pontos    (pontos)
  );

  always #5 clk = ~clk;

  // Game model: a round is either waiting for a guess or has a guess in flight
  // (m_pend counts the cycles until its verdict lands).
  int m_rest, m_pts, m_pend;
  bit m_q, m_v, m_p, m_esp, m_pc, m_pn;

  task automatic m_reset();
    m_rest = 0; m_pts = 0; m_pend = 0;
    m_q = 0; m_v = 0; m_p = 0; m_esp = 0; m_pc = 0; m_pn = 0;
  endtask

  task automatic modelo_passo();
    bit ec, en;
    int nflags;
    ec = confirma && !m_pc;
    en = novo_jogo && !m_pn;
    m_pc = confirma;
    m_pn = novo_jogo;
    nflags = int'(igual) + int'(ate3) + int'(errada);
    if (en) begin
      m_rest = MAX_TENT; m_q = 0; m_v = 0; m_p = 0; m_pend = 0; m_esp = 1;
    end else if (m_pend == 2) begin
      m_pend = 1;
    end else if (m_pend == 1) begin
      m_pend = 0;
      m_rest = m_rest - 1;
      m_q = (nflags == 1) && ate3;
      if (nflags == 1 && igual) begin
        m_v = 1;
        if (m_pts < PTS_MAX) m_pts = m_pts + 1;
      end else if (m_rest == 0) begin
        m_p = 1;
      end else begin
        m_esp = 1;
      end
    end else if (m_esp && ec) begin
      m_esp = 0;
      m_pend = 2;
    end
  endtask

  function automatic int pack(int cap, int rest, int q, int v, int p, int pts);
    return cap * 4096 + rest * 512 + q * 256 + v * 128 + p * 64 + pts;
  endfunction

  function automatic int saida();
    return pack(int'(captura), int'(restantes), int'(quente), int'(venceu),
                int'(perdeu), int'(pontos));
  endfunction

  function automatic int esperado_modelo();
    return pack(int'(m_pend == 2), m_rest, int'(m_q), int'(m_v), int'(m_p), m_pts * PONT_EN);
  endfunction

  task automatic chk(input string nome, input int atual, input int esperado);
    n_aval++;
    if (atual !== esperado) begin
      n_falhas++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nome, atual, esperado, $time);
    end
  endtask

  task automatic passo();
    @(posedge clk);
    if (rst_n) modelo_passo();
    @(negedge clk);
  endtask

  task automatic entradas(input int cf, input int nj, input int ig, input int a3, input int er);
    confirma  = cf[0];
    novo_jogo = nj[0];
    igual     = ig[0];
    ate3      = a3[0];
    errada    = er[0];
  endtask

  // One guess: confirma edge, flags presented during evaluation.
  task automatic tentativa(input int ig, input int a3, input int er);
    entradas(1, 0, 0, 0, 0);
    passo();
    chk("captura_pulso", int'(captura), 1);
    entradas(0, 0, ig, a3, er);
    passo();
    passo();
    entradas(0, 0, 0, 0, 0);
  endtask

  task automatic nova_rodada();
    entradas(0, 1, 0, 0, 0);
    passo();
    entradas(0, 0, 0, 0, 0);
    passo();
  endtask

  typedef struct {
    int cf, nj, ig, a3, er;
    int cap, rest, q, v, p, pts;
  } vetor_t;

  vetor_t tab[25];
  int     conta;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // inputs            cf nj ig a3 er   cap rest q  v  p  pts
    tab[0]  = '{0, 1, 0, 0, 0,   0, 5, 0, 0, 0, 0};
    tab[1]  = '{0, 0, 0, 0, 0,   0, 5, 0, 0, 0, 0};
    tab[2]  = '{1, 0, 0, 0, 0,   1, 5, 0, 0, 0, 0};
    tab[3]  = '{1, 0, 1, 0, 0,   0, 5, 0, 0, 0, 0};
    tab[4]  = '{0, 0, 1, 0, 0,   0, 4, 0, 1, 0, 1};
    tab[5]  = '{1, 0, 0, 0, 0,   0, 4, 0, 1, 0, 1};
    tab[6]  = '{0, 1, 0, 0, 0,   0, 5, 0, 0, 0, 1};
    tab[7]  = '{1, 1, 0, 0, 0,   1, 5, 0, 0, 0, 1};
    tab[8]  = '{0, 0, 0, 1, 0,   0, 5, 0, 0, 0, 1};
    tab[9]  = '{0, 0, 0, 1, 0,   0, 4, 1, 0, 0, 1};
    tab[10] = '{0, 0, 0, 0, 0,   0, 4, 1, 0, 0, 1};
    tab[11] = '{1, 0, 0, 0, 0,   1, 4, 1, 0, 0, 1};
    tab[12] = '{0, 0, 0, 0, 1,   0, 4, 1, 0, 0, 1};
    tab[13] = '{0, 0, 0, 0, 1,   0, 3, 0, 0, 0, 1};
    tab[14] = '{1, 1, 0, 0, 0,   0, 5, 0, 0, 0, 1};
    tab[15] = '{0, 0, 0, 0, 0,   0, 5, 0, 0, 0, 1};
    tab[16] = '{1, 0, 0, 0, 0,   1, 5, 0, 0, 0, 1};
    tab[17] = '{0, 0, 1, 1, 0,   0, 5, 0, 0, 0, 1};
    tab[18] = '{0, 0, 1, 1, 0,   0, 4, 0, 0, 0, 1};
    tab[19] = '{1, 0, 0, 0, 0,   1, 4, 0, 0, 0, 1};
    tab[20] = '{0, 0, 0, 0, 0,   0, 4, 0, 0, 0, 1};
    tab[21] = '{0, 0, 0, 0, 0,   0, 3, 0, 0, 0, 1};
    tab[22] = '{1, 0, 0, 0, 0,   1, 3, 0, 0, 0, 1};
    tab[23] = '{0, 1, 1, 0, 0,   0, 5, 0, 0, 0, 1};
    tab[24] = '{0, 0, 1, 0, 0,   0, 5, 0, 0, 0, 1};

    rst_n = 1'b0;
    entradas(0, 0, 0, 0, 0);
    m_reset();
    repeat (3) @(negedge clk);
    chk("reset_saidas", saida(), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      entradas(tab[i].cf, tab[i].nj, tab[i].ig, tab[i].a3, tab[i].er);
      passo();
      chk($sformatf("vetor_%0d", i), saida(),
          pack(tab[i].cap, tab[i].rest, tab[i].q, tab[i].v, tab[i].p, tab[i].pts * PONT_EN));
    end
    entradas(0, 0, 0, 0, 0);
    passo();

    // Five wrong guesses exhaust the round; confirma is then ignored.
    for (int i = 1; i <= 5; i++) begin
      tentativa(0, 0, 1);
      chk($sformatf("derrota_rest_%0d", i), int'(restantes), 5 - i);
      chk($sformatf("derrota_perdeu_%0d", i), int'(perdeu), int'(i == 5));
    end
    entradas(1, 0, 0, 0, 0);
    passo();
    chk("derrota_sem_captura_a", int'(captura), 0);
    passo();
    chk("derrota_sem_captura_b", int'(captura), 0);

    // Held confirma gives a single capture.
    nova_rodada();
    conta = 0;
    entradas(1, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      passo();
      conta += int'(captura);
    end
    chk("confirma_segurado", conta, 1);
    entradas(0, 0, 0, 0, 0);
    passo();

    // Sixteen wins: the score saturates and survives a new round.
    for (int i = 0; i < 16; i++) begin
      nova_rodada();
      tentativa(1, 0, 0);
    end
    chk("vitoria_venceu", int'(venceu), 1);
    chk("pontos_saturado", int'(pontos), PTS_MAX * PONT_EN);
    nova_rodada();
    chk("pontos_preservado", int'(pontos), PTS_MAX * PONT_EN);
    chk("nova_rodada_rest", int'(restantes), 5);

    // Asynchronous reset while a guess is being evaluated.
    entradas(1, 0, 0, 0, 0);
    passo();
    entradas(0, 0, 1, 0, 0);
    passo();
    #2 rst_n = 1'b0;
    #1 chk("reset_em_avalia", saida(), 0);
    m_reset();
    passo();
    rst_n = 1'b1;
    entradas(1, 0, 0, 0, 0);
    passo();
    chk("ocioso_apos_reset_a", saida(), 0);
    passo();
    chk("ocioso_apos_reset_b", saida(), 0);

    // A button held through reset release yields an edge.
    entradas(0, 1, 0, 0, 0);
    rst_n = 1'b0;
    m_reset();
    passo();
    rst_n = 1'b1;
    passo();
    chk("borda_apos_reset", int'(restantes), 5);
    entradas(0, 0, 0, 0, 0);
    passo();
    chk("modelo_sincronizado", saida(), esperado_modelo());

    for (int k = 0; k < 3000; k++) begin
      int flags;
      flags = $urandom_range(0, 7);
      entradas($urandom_range(0, 1), int'($urandom_range(0, 15) == 0),
               flags & 1, (flags >> 1) & 1, (flags >> 2) & 1);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        m_reset();
      end
      passo();
      chk("aleatorio", saida(), esperado_modelo());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_aval, n_falhas);
    $finish;
  end

endmodule
